decode_regread: RTL and testbench

- Y86-64 pipeline decode stage. It is the read side of the register file that the write-back stage writes.
- Derives the srcA/srcB/dstE/dstM register IDs from the D-register fields and drives the two register-file read ports.
- Resolves data hazards by forwarding from the E, M and W stages.
- Captures the results into the E pipeline register, with stall and bubble control.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/decode_regread_fwd_sel.sv | 27 ++
 rtl/decode_regread.sv | 114 +++++++++++
 tb/tb_decode_regread.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 opcodes, status codes, register IDs and E-register bubble values
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RSP_ID = 4'h4;
  localparam logic [2:0] BUB_STAT  = S_AOK;
  localparam logic [3:0] BUB_ICODE = I_NOP;
  localparam logic [3:0] BUB_IFUN  = 4'h0;
endpackage

// File: rtl/decode_regread_fwd_sel.sv
// fwd_sel: picks the youngest matching forwarded value for one source register, else the register-file value
module fwd_sel import y86_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       src,
  input  logic [3:0]       e_dste,
  input  logic [3:0]       m_dstm,
  input  logic [3:0]       m_dste,
  input  logic [3:0]       w_dstm,
  input  logic [3:0]       w_dste,
  input  logic [WIDTH-1:0] e_vale,
  input  logic [WIDTH-1:0] m_valm,
  input  logic [WIDTH-1:0] m_vale,
  input  logic [WIDTH-1:0] w_valm,
  input  logic [WIDTH-1:0] w_vale,
  input  logic [WIDTH-1:0] rf_val,
  output logic [WIDTH-1:0] val
);
  // dst==src with src!=RNONE already implies dst!=RNONE
  always_comb
    val = (src == RNONE) ? rf_val :
          (e_dste == src) ? e_vale :
          (m_dstm == src) ? m_valm :
          (m_dste == src) ? m_vale :
          (w_dstm == src) ? w_valm :
          (w_dste == src) ? w_vale : rf_val;
endmodule

// File: rtl/decode_regread.sv
// decode_regread: Y86-64 decode stage with register read, forwarding (DECODE_FWD_EN) and E pipeline register
module decode_regread import y86_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [3:0]       D_rA,
  input  logic [3:0]       D_rB,
  input  logic [WIDTH-1:0] D_valC,
  input  logic [WIDTH-1:0] D_valP,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  input  logic [WIDTH-1:0] rf_valA,
  input  logic [WIDTH-1:0] rf_valB,
  input  logic [3:0]       e_dstE,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [3:0]       M_icode,
  input  logic             M_Cnd,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  input  logic [WIDTH-1:0] M_valE,
  input  logic [WIDTH-1:0] m_valM,
  input  logic [3:0]       W_icode,
  input  logic             W_Cnd,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [WIDTH-1:0] W_valE,
  input  logic [WIDTH-1:0] W_valM,
  input  logic             E_stall,
  input  logic             E_bubble,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [WIDTH-1:0] E_valC,
  output logic [WIDTH-1:0] E_valA,
  output logic [WIDTH-1:0] E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB
);
  logic [3:0] d_dstE, d_dstM, q_e_dstE, q_m_dstE, q_m_dstM, q_w_dstE, q_w_dstM;
  logic [WIDTH-1:0] fwd_a, fwd_b, d_valA;
  // register IDs from the instruction fields
  always_comb begin
    d_srcA = (D_icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? D_rA :
             (D_icode inside {I_RET, I_POPQ}) ? RSP_ID : RNONE;
    d_srcB = (D_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? D_rB :
             (D_icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP_ID : RNONE;
    d_dstE = (D_icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ}) ? D_rB :
             (D_icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP_ID : RNONE;
    d_dstM = (D_icode inside {I_MRMOVQ, I_POPQ}) ? D_rA : RNONE;
  end
`ifdef DECODE_FWD_EN
  // untaken cmov in M/W never writes, so it must not forward either
  always_comb begin
    q_e_dstE = e_dstE;
    q_m_dstE = (M_icode == I_RRMOVQ && !M_Cnd) ? RNONE : M_dstE;
    q_m_dstM = (M_icode == I_RRMOVQ && !M_Cnd) ? RNONE : M_dstM;
    q_w_dstE = (W_icode == I_RRMOVQ && !W_Cnd) ? RNONE : W_dstE;
    q_w_dstM = (W_icode == I_RRMOVQ && !W_Cnd) ? RNONE : W_dstM;
  end
`else
  // without forwarding every source is masked and the register file is used directly
  always_comb begin
    q_e_dstE = RNONE;
    q_m_dstE = RNONE;
    q_m_dstM = RNONE;
    q_w_dstE = RNONE;
    q_w_dstM = RNONE;
  end
`endif
  fwd_sel #(.WIDTH(WIDTH)) u_fwd_a (
    .src(d_srcA), .e_dste(q_e_dstE), .m_dstm(q_m_dstM), .m_dste(q_m_dstE),
    .w_dstm(q_w_dstM), .w_dste(q_w_dstE), .e_vale(e_valE), .m_valm(m_valM),
    .m_vale(M_valE), .w_valm(W_valM), .w_vale(W_valE), .rf_val(rf_valA), .val(fwd_a)
  );
  fwd_sel #(.WIDTH(WIDTH)) u_fwd_b (
    .src(d_srcB), .e_dste(q_e_dstE), .m_dstm(q_m_dstM), .m_dste(q_m_dstE),
    .w_dstm(q_w_dstM), .w_dste(q_w_dstE), .e_vale(e_valE), .m_valm(m_valM),
    .m_vale(M_valE), .w_valm(W_valM), .w_vale(W_valE), .rf_val(rf_valB), .val(fwd_b)
  );
  // jumps and calls carry the return/fall-through PC in valA
  always_comb d_valA = (D_icode inside {I_JXX, I_CALL}) ? D_valP : fwd_a;
  // E pipeline register: reset/bubble insert a nop, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_stat  <= BUB_STAT;
      E_icode <= BUB_ICODE;
      E_ifun  <= BUB_IFUN;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= fwd_b;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end
endmodule

// File: tb/tb_decode_regread.sv
// tb_decode_regread: table-driven check of decode IDs, forwarding and E-register control
module tb_decode_regread;
  localparam int W = 64;
  logic clk = 0, rst_n = 0;
  logic [2:0] D_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP, rf_valA, rf_valB, e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0] d_srcA, d_srcB, e_dstE, M_icode, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
  logic M_Cnd, W_Cnd, E_stall, E_bubble;
  logic [2:0] E_stat;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [W-1:0] E_valC, E_valA, E_valB;
  int pass = 0, total = 0;

  typedef struct {
    logic [3:0] icode, ra, rb;
    logic [63:0] valc, valp, rfa, rfb;
    logic [3:0] edst;  logic [63:0] evale;
    logic [3:0] micode; logic mcnd; logic [3:0] mdste, mdstm; logic [63:0] mvale, mvalm;
    logic [3:0] wicode; logic wcnd; logic [3:0] wdste, wdstm; logic [63:0] wvale, wvalm;
    logic [3:0] x_srca, x_srcb, x_dste, x_dstm;
    logic [63:0] x_va_f, x_va_n, x_vb_f, x_vb_n;
  } vec_t;
  vec_t tbl[$];

  decode_regread #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .rf_valA(rf_valA), .rf_valB(rf_valB), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
    .m_valM(m_valM), .W_icode(W_icode), .W_Cnd(W_Cnd), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .E_stall(E_stall), .E_bubble(E_bubble),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
    .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass++;
  endtask

  function automatic vec_t dflt();
    vec_t v;
    v.icode = 4'h1; v.ra = 4'hF; v.rb = 4'hF; v.valc = 64'h0; v.valp = 64'h0;
    v.rfa = 64'h1000; v.rfb = 64'h2000; v.edst = 4'hF; v.evale = 64'hE0;
    v.micode = 4'h1; v.mcnd = 1'b1; v.mdste = 4'hF; v.mdstm = 4'hF; v.mvale = 64'hA0; v.mvalm = 64'hB0;
    v.wicode = 4'h1; v.wcnd = 1'b1; v.wdste = 4'hF; v.wdstm = 4'hF; v.wvale = 64'hC0; v.wvalm = 64'hD0;
    v.x_srca = 4'hF; v.x_srcb = 4'hF; v.x_dste = 4'hF; v.x_dstm = 4'hF;
    v.x_va_f = 64'h1000; v.x_va_n = 64'h1000; v.x_vb_f = 64'h2000; v.x_vb_n = 64'h2000;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    D_stat = 3'd1; D_icode = v.icode; D_ifun = 4'h0; D_rA = v.ra; D_rB = v.rb;
    D_valC = v.valc; D_valP = v.valp; rf_valA = v.rfa; rf_valB = v.rfb;
    e_dstE = v.edst; e_valE = v.evale; M_icode = v.micode; M_Cnd = v.mcnd;
    M_dstE = v.mdste; M_dstM = v.mdstm; M_valE = v.mvale; m_valM = v.mvalm;
    W_icode = v.wicode; W_Cnd = v.wcnd; W_dstE = v.wdste; W_dstM = v.wdstm;
    W_valE = v.wvale; W_valM = v.wvalm;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".stat"}, 64'(E_stat), 64'd1);
    chk({tag, ".icode"}, 64'(E_icode), 64'h1);
    chk({tag, ".valC"}, E_valC, 64'h0);
    chk({tag, ".ids"}, 64'({E_dstE, E_dstM, E_srcA, E_srcB}), 64'hFFFF);
  endtask

  initial begin
    vec_t v;
    logic [63:0] ea, eb;
    logic [3:0] hold_icode;
    logic [63:0] hold_vala;
    // opq rA=0 rB=3, e forwards r0
    v = dflt(); v.icode = 4'h6; v.ra = 4'h0; v.rb = 4'h3; v.rfa = 64'h1; v.edst = 4'h0; v.evale = 64'h11;
    v.x_srca = 4'h0; v.x_srcb = 4'h3; v.x_dste = 4'h3; v.x_va_f = 64'h11; v.x_va_n = 64'h1; tbl.push_back(v);
    // rmmovq rA=5: M_dstE beats W_dstE
    v = dflt(); v.icode = 4'h4; v.ra = 4'h5; v.rb = 4'h6; v.mdste = 4'h5; v.mvale = 64'hAA; v.wdste = 4'h5; v.wvale = 64'hBB;
    v.x_srca = 4'h5; v.x_srcb = 4'h6; v.x_va_f = 64'hAA; tbl.push_back(v);
    // rrmovq rA=1, W untaken cmov: no forwarding
    v = dflt(); v.icode = 4'h2; v.ra = 4'h1; v.rb = 4'h7; v.rfa = 64'h8; v.wicode = 4'h2; v.wcnd = 1'b0; v.wdste = 4'h1; v.wvale = 64'h99;
    v.x_srca = 4'h1; v.x_dste = 4'h7; v.x_va_f = 64'h8; v.x_va_n = 64'h8; tbl.push_back(v);
    // same with taken cmov
    v.wcnd = 1'b1; v.x_va_f = 64'h99; tbl.push_back(v);
    // popq rA=4
    v = dflt(); v.icode = 4'hB; v.ra = 4'h4;
    v.x_srca = 4'h4; v.x_srcb = 4'h4; v.x_dste = 4'h4; v.x_dstm = 4'h4; tbl.push_back(v);
    // pushq after popq: M_dstM beats M_dstE on rsp
    v = dflt(); v.icode = 4'hA; v.ra = 4'h3; v.mdstm = 4'h4; v.mdste = 4'h4; v.mvalm = 64'h7; v.mvale = 64'h108;
    v.x_srca = 4'h3; v.x_srcb = 4'h4; v.x_dste = 4'h4; v.x_vb_f = 64'h7; tbl.push_back(v);
    // call: valA=valP even with an e match on nothing; valB from W_dstM
    v = dflt(); v.icode = 4'h8; v.valp = 64'h40; v.wdstm = 4'h4; v.wvalm = 64'h33;
    v.x_srcb = 4'h4; v.x_dste = 4'h4; v.x_va_f = 64'h40; v.x_va_n = 64'h40; v.x_vb_f = 64'h33; tbl.push_back(v);
    // mrmovq: W_dstM beats W_dstE
    v = dflt(); v.icode = 4'h5; v.ra = 4'h2; v.rb = 4'h9; v.wdstm = 4'h9; v.wvalm = 64'h77; v.wdste = 4'h9; v.wvale = 64'h66;
    v.x_srcb = 4'h9; v.x_dstm = 4'h2; v.x_vb_f = 64'h77; tbl.push_back(v);
    // jxx: valA=valP
    v = dflt(); v.icode = 4'h7; v.valp = 64'h123; v.x_va_f = 64'h123; v.x_va_n = 64'h123; tbl.push_back(v);
    // ret: e beats M_dstM on rsp
    v = dflt(); v.icode = 4'h9; v.edst = 4'h4; v.evale = 64'h5; v.mdstm = 4'h4; v.mvalm = 64'h6;
    v.x_srca = 4'h4; v.x_srcb = 4'h4; v.x_dste = 4'h4; v.x_va_f = 64'h5; v.x_vb_f = 64'h5; tbl.push_back(v);
    // opq r1,r1: untaken cmov in M skipped, W forwards
    v = dflt(); v.icode = 4'h6; v.ra = 4'h1; v.rb = 4'h1; v.micode = 4'h2; v.mcnd = 1'b0; v.mdste = 4'h1; v.mvale = 64'h55;
    v.wdste = 4'h1; v.wvale = 64'h44; v.x_srca = 4'h1; v.x_srcb = 4'h1; v.x_dste = 4'h1; v.x_va_f = 64'h44; v.x_vb_f = 64'h44; tbl.push_back(v);
    // halt with a stray e_dstE=F: no forwarding on RNONE
    v = dflt(); v.icode = 4'h0; tbl.push_back(v);

    // reset: bubble while held, first post-reset edge captures irmovq
    E_stall = 0; E_bubble = 0;
    v = dflt(); v.icode = 4'h3; v.rb = 4'h2; v.valc = 64'h55; drive(v);
    repeat (2) @(posedge clk);
    #1 chk_bubble("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("rst_rel.icode", 64'(E_icode), 64'h3);
    chk("rst_rel.dstE", 64'(E_dstE), 64'h2);
    chk("rst_rel.valC", E_valC, 64'h55);
    chk("rst_rel.srcs", 64'({E_srcA, E_srcB}), 64'hFF);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
`ifdef DECODE_FWD_EN
      ea = tbl[i].x_va_f; eb = tbl[i].x_vb_f;
`else
      ea = tbl[i].x_va_n; eb = tbl[i].x_vb_n;
`endif
      #1;
      chk($sformatf("v%0d.d_srcA", i), 64'(d_srcA), 64'(tbl[i].x_srca));
      chk($sformatf("v%0d.d_srcB", i), 64'(d_srcB), 64'(tbl[i].x_srcb));
      @(posedge clk); #1;
      chk($sformatf("v%0d.icode", i), 64'(E_icode), 64'(tbl[i].icode));
      chk($sformatf("v%0d.dstE", i), 64'(E_dstE), 64'(tbl[i].x_dste));
      chk($sformatf("v%0d.dstM", i), 64'(E_dstM), 64'(tbl[i].x_dstm));
      chk($sformatf("v%0d.srcs", i), 64'({E_srcA, E_srcB}), 64'({tbl[i].x_srca, tbl[i].x_srcb}));
      chk($sformatf("v%0d.valA", i), E_valA, ea);
      chk($sformatf("v%0d.valB", i), E_valB, eb);
    end

    // stall holds, bubble beats stall, then call loads
    hold_icode = E_icode; hold_vala = E_valA;
    v = dflt(); v.icode = 4'h6; v.ra = 4'h2; v.rb = 4'h3; drive(v); E_stall = 1;
    @(posedge clk); #1;
    chk("stall.icode", 64'(E_icode), 64'(hold_icode));
    chk("stall.valA", E_valA, hold_vala);
    E_bubble = 1;
    @(posedge clk); #1;
    chk_bubble("bub_stall");
    E_bubble = 0; E_stall = 0;
    v = dflt(); v.icode = 4'h8; v.valp = 64'h40; drive(v);
    @(posedge clk); #1;
    chk("call.valA", E_valA, 64'h40);
    chk("call.dstE", 64'(E_dstE), 64'h4);
    chk("call.srcB", 64'(E_srcB), 64'h4);

    // asynchronous reset mid-cycle
    @(negedge clk); rst_n = 0; #1;
    chk_bubble("async_rst");
    rst_n = 1;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
